multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle MIPS control FSM. Sequences a shared-ALU datapath with one unified instruction/data memory through the FETCH, DECODE, EXEC, MEMACC and WB states.
- Drives the datapath select and enable strobes. Uses the same ALUOp, NPCOp, GPRSel and WDSel encodings as the single-cycle controller.
- Waits on a memory ready handshake in every state that accesses memory. Includes a stall watchdog.
- Op/Funct come from the external IR, which is loaded at the end of FETCH. Zero comes from the ALU.

Parameters:
STALL_LIMIT, 255, maximum consecutive wait cycles on mem_ready before abort; 0 disables the watchdog.
CNT_W, 8, width of the stall counter; must satisfy STALL_LIMIT < 2^CNT_W.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
Op  in  6  IR[31:26]
Funct  in  6  IR[5:0]
Zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current MemRead/MemWrite this cycle
PCWrite  out  1  PC load enable
IRWrite  out  1  IR load enable
RegWrite  out  1  register-file write
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IorD  out  1  memory address: 0 = PC, 1 = ALUOut
ALUSrcA  out  1  0 = PC, 1 = register A
ALUSrcB  out  2  00 = register B, 01 = const 4, 10 = ext imm, 11 = ext imm<<2
EXTOp  out  1  1 = sign extend, 0 = zero extend
ALUOp  out  4  NOP 0000, ADD 0001, SUB 0010, AND 0011, OR 0100, SLT 0101
NPCOp  out  2  00 = ALU result (PC+4), 01 = ALUOut branch target, 10 = jump target
GPRSel  out  2  00 = rd, 01 = rt, 10 = $31
WDSel  out  2  00 = ALUOut, 01 = MDR, 10 = PC
retire  out  1  1-cycle pulse on the final cycle of each instruction
illegal  out  1  1-cycle pulse in DECODE for an unsupported opcode/funct
mem_err  out  1  1-cycle pulse on watchdog abort
state  out  3  FETCH 0, DECODE 1, EXEC 2, MEMACC 3, WB 4

Behaviour:
- Supported instructions: add, sub, and, or, slt (R-type); addi, ori, lw, sw, beq, bne, j, jal.
- Outputs are combinational from the state register, the decoded Op/Funct, Zero and mem_ready. Any signal not listed for a state is 0.
- Reset: state <= FETCH, stall counter <= 0. While rst=1, every enable, request and pulse output is forced to 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD.
  - On mem_ready: IRWrite=1, PCWrite=1, NPCOp=00, next state DECODE. Otherwise hold.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, EXTOp=1, ALUOp=ADD (branch target into ALUOut).
  - j: PCWrite=1, NPCOp=10, retire=1, next FETCH.
  - jal: same as j, plus RegWrite=1, GPRSel=10, WDSel=10. PC+4 is written on the same edge that the PC updates.
  - Unsupported: illegal=1, retire=0, next FETCH.
  - Anything else: next EXEC.
- EXEC:
  - R-type: ALUSrcA=1, ALUSrcB=00, ALUOp from Funct; next WB.
  - addi/lw/sw: ALUSrcA=1, ALUSrcB=10, EXTOp=1, ALUOp=ADD. lw/sw go to MEMACC, addi goes to WB.
  - ori: ALUSrcA=1, ALUSrcB=10, EXTOp=0, ALUOp=OR; next WB.
  - beq/bne: ALUSrcA=1, ALUSrcB=00, ALUOp=SUB, NPCOp=01. PCWrite = (beq & Zero) | (bne & ~Zero). retire=1, next FETCH.
- MEMACC:
  - IorD=1. lw: MemRead=1. sw: MemWrite=1.
  - Request is held until mem_ready.
  - sw: retire=1 and next FETCH on mem_ready.
  - lw: next WB on mem_ready (MDR captures externally).
- WB:
  - RegWrite=1, retire=1, next FETCH.
  - R-type: GPRSel=00, WDSel=00. addi/ori: GPRSel=01, WDSel=00. lw: GPRSel=01, WDSel=01.
- Latency in cycles with zero wait: R-type/addi/ori 4, lw 5, sw 4, beq/bne 3, j/jal 2. Each wait cycle adds 1.
- Watchdog:
  - The counter increments each FETCH/MEMACC cycle with mem_ready=0. It clears on mem_ready and on any state change.
  - When the counter equals STALL_LIMIT (STALL_LIMIT≠0) and mem_ready=0: drop requests, mem_err=1, no PC/IR/Reg write, next FETCH.
  - The PC is unchanged, so the same instruction is refetched.
  - mem_ready in the limit cycle wins over the abort.
- rst asserted mid-instruction: abort immediately with no writes; FETCH on the next cycle.

Test Plan:
- add with mem_ready always 1 → states 0,1,2,4; ALUOp=0001 in EXEC; RegWrite=1, GPRSel=00 in WB; retire in cycle 4.
- lw with mem_ready low 3 cycles in MEMACC → MemRead/IorD=1 held 4 cycles; WDSel=01, GPRSel=01 in WB; total 8 cycles.
- beq with Zero=1, then bne with Zero=1 → PCWrite=1, NPCOp=01 for beq; PCWrite=0 for bne; each 3 cycles.
- jal → cycle 2 shows PCWrite=1, NPCOp=10, RegWrite=1, GPRSel=10, WDSel=10, retire=1.
- Op=6'h3F → illegal pulse in DECODE, no writes, back to FETCH.
- STALL_LIMIT=4 with mem_ready held 0 in FETCH → mem_err on the 5th wait cycle, state stays FETCH, PCWrite never set; rst mid-EXEC → FETCH with no RegWrite.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//   Control FSM for a multi-cycle MIPS datapath built around a shared ALU and
//   one unified instruction/data memory. Steps each instruction through
//   FETCH -> DECODE -> EXEC -> MEMACC -> WB (skipping states it does not need).
//   Every state that touches memory waits on mem_ready. A stall watchdog
//   abandons a wait that runs too long and refetches the same instruction.
//
// Parameters
//   STALL_LIMIT : maximum consecutive mem_ready=0 cycles before abort
//                 (0 disables the watchdog)
//   CNT_W       : stall counter width, STALL_LIMIT < 2**CNT_W
//
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   Op, Funct           : IR[31:26], IR[5:0] from the external IR
//   Zero                : ALU zero flag
//   mem_ready           : memory completes the current request this cycle
//   PCWrite, IRWrite    : PC / IR load enables
//   RegWrite            : register-file write
//   MemRead, MemWrite   : memory requests
//   IorD                : memory address select (0 = PC, 1 = ALUOut)
//   ALUSrcA, ALUSrcB    : ALU operand selects
//   EXTOp               : 1 = sign extend, 0 = zero extend
//   ALUOp, NPCOp        : ALU operation, next-PC source
//   GPRSel, WDSel       : write register select, write data select
//   retire              : pulse on the final cycle of each instruction
//   illegal             : pulse in DECODE for an unsupported instruction
//   mem_err             : pulse on watchdog abort
//   state               : current FSM state
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int STALL_LIMIT = 255,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       EXTOp,
    output logic [3:0] ALUOp,
    output logic [1:0] NPCOp,
    output logic [1:0] GPRSel,
    output logic [1:0] WDSel,
    output logic       retire,
    output logic       illegal,
    output logic       mem_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEMACC = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0001;
    localparam logic [3:0] ALU_SUB = 4'b0010;
    localparam logic [3:0] ALU_AND = 4'b0011;
    localparam logic [3:0] ALU_OR  = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_LIMIT);

    state_t           cur_state;
    state_t           nxt_state;
    logic [CNT_W-1:0] stall_cnt;

    // Instruction decode (the IR is stable from DECODE onward)
    logic is_rtype, r_add, r_sub, r_and, r_or, r_slt, r_ok;
    logic is_addi, is_ori, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, legal;

    assign is_rtype = (Op == 6'b000000);
    assign r_add    = (Funct == 6'b100000);
    assign r_sub    = (Funct == 6'b100010);
    assign r_and    = (Funct == 6'b100100);
    assign r_or     = (Funct == 6'b100101);
    assign r_slt    = (Funct == 6'b101010);
    assign r_ok     = r_add | r_sub | r_and | r_or | r_slt;
    assign is_addi  = (Op == 6'b001000);
    assign is_ori   = (Op == 6'b001101);
    assign is_lw    = (Op == 6'b100011);
    assign is_sw    = (Op == 6'b101011);
    assign is_beq   = (Op == 6'b000100);
    assign is_bne   = (Op == 6'b000101);
    assign is_j     = (Op == 6'b000010);
    assign is_jal   = (Op == 6'b000011);
    assign legal    = (is_rtype & r_ok) | is_addi | is_ori | is_lw | is_sw |
                      is_beq | is_bne | is_j | is_jal;

    // Abort only while actually waiting; a mem_ready in the limit cycle wins.
    logic wd_hit;
    assign wd_hit = (STALL_LIMIT != 0) && (stall_cnt == LIMIT) && !mem_ready &&
                    ((cur_state == S_FETCH) || (cur_state == S_MEMACC));

    assign state = cur_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_FETCH;
            stall_cnt <= '0;
        end else begin
            cur_state <= nxt_state;
            if (mem_ready || wd_hit || (nxt_state != cur_state))
                stall_cnt <= '0;
            else if ((cur_state == S_FETCH) || (cur_state == S_MEMACC))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        nxt_state = cur_state;
        PCWrite   = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IorD      = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        EXTOp     = 1'b0;
        ALUOp     = ALU_NOP;
        NPCOp     = 2'b00;
        GPRSel    = 2'b00;
        WDSel     = 2'b00;
        retire    = 1'b0;
        illegal   = 1'b0;
        mem_err   = 1'b0;

        case (cur_state)
            S_FETCH: begin
                if (wd_hit) begin
                    // PC untouched, so the same instruction is refetched
                    mem_err   = 1'b1;
                    nxt_state = S_FETCH;
                end else begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    ALUOp   = ALU_ADD;
                    if (mem_ready) begin
                        IRWrite   = 1'b1;
                        PCWrite   = 1'b1;
                        nxt_state = S_DECODE;
                    end
                end
            end
            S_DECODE: begin
                // Branch target computed speculatively into ALUOut
                ALUSrcB = 2'b11;
                EXTOp   = 1'b1;
                ALUOp   = ALU_ADD;
                if (is_j || is_jal) begin
                    PCWrite   = 1'b1;
                    NPCOp     = 2'b10;
                    retire    = 1'b1;
                    nxt_state = S_FETCH;
                    if (is_jal) begin
                        // PC still holds PC+4 on this edge, so link from PC
                        RegWrite = 1'b1;
                        GPRSel   = 2'b10;
                        WDSel    = 2'b10;
                    end
                end else if (!legal) begin
                    illegal   = 1'b1;
                    nxt_state = S_FETCH;
                end else begin
                    nxt_state = S_EXEC;
                end
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                if (is_rtype) begin
                    ALUSrcB   = 2'b00;
                    ALUOp     = r_add ? ALU_ADD :
                                r_sub ? ALU_SUB :
                                r_and ? ALU_AND :
                                r_or  ? ALU_OR  :
                                r_slt ? ALU_SLT : ALU_NOP;
                    nxt_state = S_WB;
                end else if (is_addi || is_lw || is_sw) begin
                    ALUSrcB   = 2'b10;
                    EXTOp     = 1'b1;
                    ALUOp     = ALU_ADD;
                    nxt_state = is_addi ? S_WB : S_MEMACC;
                end else if (is_ori) begin
                    ALUSrcB   = 2'b10;
                    ALUOp     = ALU_OR;
                    nxt_state = S_WB;
                end else begin
                    // beq / bne
                    ALUSrcB   = 2'b00;
                    ALUOp     = ALU_SUB;
                    NPCOp     = 2'b01;
                    PCWrite   = (is_beq & Zero) | (is_bne & ~Zero);
                    retire    = 1'b1;
                    nxt_state = S_FETCH;
                end
            end
            S_MEMACC: begin
                if (wd_hit) begin
                    mem_err   = 1'b1;
                    nxt_state = S_FETCH;
                end else begin
                    IorD     = 1'b1;
                    MemRead  = is_lw;
                    MemWrite = is_sw;
                    if (mem_ready) begin
                        retire    = is_sw;
                        nxt_state = is_lw ? S_WB : S_FETCH;
                    end
                end
            end
            S_WB: begin
                RegWrite  = 1'b1;
                retire    = 1'b1;
                GPRSel    = is_rtype ? 2'b00 : 2'b01;
                WDSel     = is_lw ? 2'b01 : 2'b00;
                nxt_state = S_FETCH;
            end
            default: nxt_state = S_FETCH;
        endcase

        // Reset aborts the instruction with no side effects
        if (rst) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            IorD     = 1'b0;
            ALUSrcA  = 1'b0;
            ALUSrcB  = 2'b00;
            EXTOp    = 1'b0;
            ALUOp    = ALU_NOP;
            NPCOp    = 2'b00;
            GPRSel   = 2'b00;
            WDSel    = 2'b00;
            retire   = 1'b0;
            illegal  = 1'b0;
            mem_err  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl (STALL_LIMIT = 4). Inputs are driven
//   just after the falling edge; combinational outputs are sampled 1 ns later,
//   well away from the rising edge that advances the FSM.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_JAL  = 6'h03;
    localparam logic [5:0] OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_BAD  = 6'h3F;
    localparam logic [5:0] F_ADD   = 6'h20;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] Op;
    logic [5:0] Funct;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, IRWrite, RegWrite, MemRead, MemWrite, IorD, ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       EXTOp;
    logic [3:0] ALUOp;
    logic [1:0] NPCOp, GPRSel, WDSel;
    logic       retire, illegal, mem_err;
    logic [2:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(.STALL_LIMIT(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
        .IorD(IorD), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .EXTOp(EXTOp),
        .ALUOp(ALUOp), .NPCOp(NPCOp), .GPRSel(GPRSel), .WDSel(WDSel),
        .retire(retire), .illegal(illegal), .mem_err(mem_err), .state(state)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic mr);
        Op = op; Funct = fn; Zero = z; mem_ready = mr;
        #1;
    endtask

    task automatic next_cyc;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // ---- reset: enables forced low even though FETCH would request ----
        rst = 1'b1;
        drive(OP_R, F_ADD, 1'b0, 1'b1);
        next_cyc();
        #1;
        chk("rst_state",   8'(state),   8'd0);
        chk("rst_memread", 8'(MemRead), 8'd0);
        chk("rst_pcwrite", 8'(PCWrite), 8'd0);
        chk("rst_irwrite", 8'(IRWrite), 8'd0);
        rst = 1'b0;

        // ---- add, no waits: 0,1,2,4 ----
        drive(OP_R, F_ADD, 1'b0, 1'b1);
        chk("add_c1_state", 8'(state),   8'd0);
        chk("add_c1_mrd",   8'(MemRead), 8'd1);
        chk("add_c1_irw",   8'(IRWrite), 8'd1);
        chk("add_c1_pcw",   8'(PCWrite), 8'd1);
        chk("add_c1_srcb",  8'(ALUSrcB), 8'd1);
        next_cyc(); drive(OP_R, F_ADD, 1'b0, 1'b1);
        chk("add_c2_state", 8'(state),   8'd1);
        chk("add_c2_srcb",  8'(ALUSrcB), 8'd3);
        chk("add_c2_pcw",   8'(PCWrite), 8'd0);
        next_cyc(); drive(OP_R, F_ADD, 1'b0, 1'b1);
        chk("add_c3_state", 8'(state),   8'd2);
        chk("add_c3_aluop", 8'(ALUOp),   8'd1);
        chk("add_c3_srca",  8'(ALUSrcA), 8'd1);
        next_cyc(); drive(OP_R, F_ADD, 1'b0, 1'b1);
        chk("add_c4_state", 8'(state),   8'd4);
        chk("add_c4_regw",  8'(RegWrite), 8'd1);
        chk("add_c4_gpr",   8'(GPRSel),  8'd0);
        chk("add_c4_ret",   8'(retire),  8'd1);

        // ---- lw with 3 wait cycles in MEMACC: 8 cycles ----
        next_cyc(); drive(OP_LW, 6'h00, 1'b0, 1'b1);
        chk("lw_c1_state", 8'(state), 8'd0);
        next_cyc(); drive(OP_LW, 6'h00, 1'b0, 1'b1);
        chk("lw_c2_state", 8'(state), 8'd1);
        next_cyc(); drive(OP_LW, 6'h00, 1'b0, 1'b1);
        chk("lw_c3_srcb",  8'(ALUSrcB), 8'd2);
        chk("lw_c3_ext",   8'(EXTOp),   8'd1);
        for (int i = 0; i < 4; i++) begin
            next_cyc(); drive(OP_LW, 6'h00, 1'b0, (i == 3));
            chk("lw_mem_state", 8'(state),   8'd3);
            chk("lw_mem_mrd",   8'(MemRead), 8'd1);
            chk("lw_mem_iord",  8'(IorD),    8'd1);
            chk("lw_mem_ret",   8'(retire),  8'd0);
        end
        next_cyc(); drive(OP_LW, 6'h00, 1'b0, 1'b1);
        chk("lw_c8_state", 8'(state),    8'd4);
        chk("lw_c8_wd",    8'(WDSel),    8'd1);
        chk("lw_c8_gpr",   8'(GPRSel),   8'd1);
        chk("lw_c8_ret",   8'(retire),   8'd1);

        // ---- beq taken with Zero=1: 3 cycles ----
        next_cyc(); drive(OP_BEQ, 6'h00, 1'b1, 1'b1);
        next_cyc(); drive(OP_BEQ, 6'h00, 1'b1, 1'b1);
        next_cyc(); drive(OP_BEQ, 6'h00, 1'b1, 1'b1);
        chk("beq_state", 8'(state),   8'd2);
        chk("beq_pcw",   8'(PCWrite), 8'd1);
        chk("beq_npc",   8'(NPCOp),   8'd1);
        chk("beq_alu",   8'(ALUOp),   8'd2);
        chk("beq_ret",   8'(retire),  8'd1);

        // ---- bne not taken with Zero=1 ----
        next_cyc(); drive(OP_BNE, 6'h00, 1'b1, 1'b1);
        chk("bne_c1_state", 8'(state), 8'd0);
        next_cyc(); drive(OP_BNE, 6'h00, 1'b1, 1'b1);
        next_cyc(); drive(OP_BNE, 6'h00, 1'b1, 1'b1);
        chk("bne_state", 8'(state),   8'd2);
        chk("bne_pcw",   8'(PCWrite), 8'd0);
        chk("bne_ret",   8'(retire),  8'd1);

        // ---- jal: done in DECODE ----
        next_cyc(); drive(OP_JAL, 6'h00, 1'b0, 1'b1);
        chk("jal_c1_state", 8'(state), 8'd0);
        next_cyc(); drive(OP_JAL, 6'h00, 1'b0, 1'b1);
        chk("jal_state", 8'(state),    8'd1);
        chk("jal_pcw",   8'(PCWrite),  8'd1);
        chk("jal_npc",   8'(NPCOp),    8'd2);
        chk("jal_regw",  8'(RegWrite), 8'd1);
        chk("jal_gpr",   8'(GPRSel),   8'd2);
        chk("jal_wd",    8'(WDSel),    8'd2);
        chk("jal_ret",   8'(retire),   8'd1);

        // ---- sw, no waits: 4 cycles ----
        next_cyc(); drive(OP_SW, 6'h00, 1'b0, 1'b1);
        chk("sw_c1_state", 8'(state), 8'd0);
        next_cyc(); drive(OP_SW, 6'h00, 1'b0, 1'b1);
        next_cyc(); drive(OP_SW, 6'h00, 1'b0, 1'b1);
        next_cyc(); drive(OP_SW, 6'h00, 1'b0, 1'b1);
        chk("sw_state", 8'(state),    8'd3);
        chk("sw_mwr",   8'(MemWrite), 8'd1);
        chk("sw_mrd",   8'(MemRead),  8'd0);
        chk("sw_ret",   8'(retire),   8'd1);

        // ---- ori: zero extend, OR, writes rt ----
        next_cyc(); drive(OP_ORI, 6'h00, 1'b0, 1'b1);
        chk("ori_c1_state", 8'(state), 8'd0);
        next_cyc(); drive(OP_ORI, 6'h00, 1'b0, 1'b1);
        next_cyc(); drive(OP_ORI, 6'h00, 1'b0, 1'b1);
        chk("ori_alu", 8'(ALUOp), 8'd4);
        chk("ori_ext", 8'(EXTOp), 8'd0);
        next_cyc(); drive(OP_ORI, 6'h00, 1'b0, 1'b1);
        chk("ori_gpr", 8'(GPRSel), 8'd1);

        // ---- illegal opcode ----
        next_cyc(); drive(OP_BAD, 6'h00, 1'b0, 1'b1);
        next_cyc(); drive(OP_BAD, 6'h00, 1'b0, 1'b1);
        chk("ill_state", 8'(state),    8'd1);
        chk("ill_pulse", 8'(illegal),  8'd1);
        chk("ill_pcw",   8'(PCWrite),  8'd0);
        chk("ill_regw",  8'(RegWrite), 8'd0);
        chk("ill_ret",   8'(retire),   8'd0);
        next_cyc(); drive(OP_R, 6'h3F, 1'b0, 1'b1);
        chk("ill_back", 8'(state), 8'd0);

        // ---- R-type with unsupported funct is also illegal ----
        next_cyc(); drive(OP_R, 6'h3F, 1'b0, 1'b1);
        chk("illf_pulse", 8'(illegal), 8'd1);

        // ---- watchdog: 5th wait cycle in FETCH aborts ----
        for (int i = 0; i < 5; i++) begin
            next_cyc(); drive(OP_R, F_ADD, 1'b0, 1'b0);
            chk("wd_state", 8'(state),   8'd0);
            chk("wd_pcw",   8'(PCWrite), 8'd0);
            chk("wd_err",   8'(mem_err), (i == 4) ? 8'd1 : 8'd0);
            chk("wd_mrd",   8'(MemRead), (i == 4) ? 8'd0 : 8'd1);
        end
        // counter restarted: first wait after abort is quiet
        next_cyc(); drive(OP_R, F_ADD, 1'b0, 1'b0);
        chk("wd_after_err", 8'(mem_err), 8'd0);
        chk("wd_after_mrd", 8'(MemRead), 8'd1);
        // three more waits bring the count to the limit; mem_ready then wins
        for (int i = 0; i < 3; i++) begin
            next_cyc(); drive(OP_R, F_ADD, 1'b0, 1'b0);
        end
        next_cyc(); drive(OP_R, F_ADD, 1'b0, 1'b1);
        chk("wd_win_err", 8'(mem_err), 8'd0);
        chk("wd_win_irw", 8'(IRWrite), 8'd1);

        // ---- rst asserted mid-EXEC ----
        next_cyc(); drive(OP_R, F_ADD, 1'b0, 1'b1);
        chk("rx_dec", 8'(state), 8'd1);
        next_cyc(); drive(OP_R, F_ADD, 1'b0, 1'b1);
        chk("rx_exec", 8'(state), 8'd2);
        rst = 1'b1;
        #1;
        chk("rx_alu_forced", 8'(ALUOp), 8'd0);
        next_cyc();
        rst = 1'b0;
        drive(OP_R, F_ADD, 1'b0, 1'b1);
        chk("rx_state", 8'(state),    8'd0);
        chk("rx_regw",  8'(RegWrite), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
